// File: rtl/cache_fill_ctrl_pkg.sv
// Shared types and constants for the cache fill controller.
// Build option: FILL_CRITICAL_WORD_FIRST_EN (see cache_fill_ctrl.sv).
package cache_fill_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } fill_state_e;

    localparam int BLOCK_WORDS      = 8;
    localparam int MEM_READ_LATENCY = 4;

    localparam logic FILL_SEL_I = 1'b0;
    localparam logic FILL_SEL_D = 1'b1;

endpackage

// File: rtl/cache_fill_ctrl_if.sv
// Cache/memory side bundle of the fill controller; master = controller, slave = caches + memory.
interface cache_fill_ctrl_if #(
    parameter int ADDR_WIDTH = 16
);
    logic                  i_miss;
    logic [ADDR_WIDTH-1:0] i_miss_addr;
    logic                  d_miss;
    logic [ADDR_WIDTH-1:0] d_miss_addr;
    logic                  d_wr_req;
    logic [ADDR_WIDTH-1:0] d_wr_addr;
    logic [15:0]           d_wr_data;
    logic                  d_wr_ack;
    logic                  fill_we;
    logic                  fill_sel;
    logic [2:0]            fill_word_idx;
    logic [15:0]           fill_data;
    logic                  i_fill_done;
    logic                  d_fill_done;
    logic                  mem_enable;
    logic                  mem_wr;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [15:0]           mem_data_in;
    logic [15:0]           mem_data_out;
    logic                  mem_data_valid;

    modport master (
        input  i_miss, i_miss_addr, d_miss, d_miss_addr,
        input  d_wr_req, d_wr_addr, d_wr_data,
        input  mem_data_out, mem_data_valid,
        output d_wr_ack, fill_we, fill_sel, fill_word_idx, fill_data,
        output i_fill_done, d_fill_done,
        output mem_enable, mem_wr, mem_addr, mem_data_in
    );

    modport slave (
        output i_miss, i_miss_addr, d_miss, d_miss_addr,
        output d_wr_req, d_wr_addr, d_wr_data,
        output mem_data_out, mem_data_valid,
        input  d_wr_ack, fill_we, fill_sel, fill_word_idx, fill_data,
        input  i_fill_done, d_fill_done,
        input  mem_enable, mem_wr, mem_addr, mem_data_in
    );

endinterface

// File: rtl/cache_fill_ctrl_fill_counter.sv
// Issue/receive counter pair for one block fill; word indices wrap modulo the block size.
module cache_fill_ctrl_fill_counter
    import cache_fill_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [2:0] start,
    input  logic       issue_en,
    input  logic       recv_en,
    output logic       issue_done,
    output logic [2:0] issue_idx,
    output logic [2:0] recv_idx,
    output logic       recv_last
);

    logic [3:0] iss_q, iss_d;
    logic [3:0] rcv_q, rcv_d;
    logic [2:0] start_q, start_d;

    always_comb begin
        iss_d   = iss_q;
        rcv_d   = rcv_q;
        start_d = start_q;
        if (load) begin
            iss_d   = 4'd0;
            rcv_d   = 4'd0;
            start_d = start;
        end else begin
            if (issue_en) iss_d = iss_q + 4'd1;
            if (recv_en)  rcv_d = rcv_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            iss_q   <= 4'd0;
            rcv_q   <= 4'd0;
            start_q <= 3'd0;
        end else begin
            iss_q   <= iss_d;
            rcv_q   <= rcv_d;
            start_q <= start_d;
        end
    end

    // 3-bit sums drop the carry, which is exactly the in-block wrap.
    assign issue_done = (iss_q == 4'(BLOCK_WORDS));
    assign issue_idx  = start_q + iss_q[2:0];
    assign recv_idx   = start_q + rcv_q[2:0];
    assign recv_last  = (rcv_q == 4'(BLOCK_WORDS - 1));

endmodule

// File: rtl/cache_fill_ctrl.sv
// Arbitrates I/D misses and D write-through stores onto a 4-cycle-read memory and streams block fills.
// Build option: FILL_CRITICAL_WORD_FIRST_EN starts each fill at the missed word instead of word 0.
module cache_fill_ctrl
    import cache_fill_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    cache_fill_ctrl_if.master bus
);

    localparam int BASE_W = ADDR_WIDTH - 4;

    fill_state_e       state_q, state_d;
    logic [BASE_W-1:0] base_q, base_d;
    logic              sel_q, sel_d;

    logic       cnt_load;
    logic [2:0] cnt_start;
    logic       issue_en;
    logic       recv_en;
    logic       issue_done;
    logic [2:0] issue_idx;
    logic [2:0] recv_idx;
    logic       recv_last;

    cache_fill_ctrl_fill_counter u_fill_counter (
        .clk        (clk),
        .rst        (rst),
        .load       (cnt_load),
        .start      (cnt_start),
        .issue_en   (issue_en),
        .recv_en    (recv_en),
        .issue_done (issue_done),
        .issue_idx  (issue_idx),
        .recv_idx   (recv_idx),
        .recv_last  (recv_last)
    );

    // Outputs are held at zero while rst is high so a reset mid-fill never leaks a stray access.
    always_comb begin
        state_d            = state_q;
        base_d             = base_q;
        sel_d              = sel_q;
        cnt_load           = 1'b0;
        cnt_start          = 3'd0;
        issue_en           = 1'b0;
        recv_en            = 1'b0;
        bus.d_wr_ack       = 1'b0;
        bus.fill_we        = 1'b0;
        bus.fill_sel       = FILL_SEL_I;
        bus.fill_word_idx  = 3'd0;
        bus.fill_data      = 16'd0;
        bus.i_fill_done    = 1'b0;
        bus.d_fill_done    = 1'b0;
        bus.mem_enable     = 1'b0;
        bus.mem_wr         = 1'b0;
        bus.mem_addr       = '0;
        bus.mem_data_in    = 16'd0;

        if (!rst) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.d_wr_req) begin
                        bus.mem_enable  = 1'b1;
                        bus.mem_wr      = 1'b1;
                        bus.mem_addr    = bus.d_wr_addr;
                        bus.mem_data_in = bus.d_wr_data;
                        bus.d_wr_ack    = 1'b1;
                    end else if (bus.d_miss) begin
                        sel_d    = FILL_SEL_D;
                        base_d   = bus.d_miss_addr[ADDR_WIDTH-1:4];
                        cnt_load = 1'b1;
`ifdef FILL_CRITICAL_WORD_FIRST_EN
                        cnt_start = bus.d_miss_addr[3:1];
`else
                        cnt_start = 3'd0;
`endif
                        state_d  = ST_FILL;
                    end else if (bus.i_miss) begin
                        sel_d    = FILL_SEL_I;
                        base_d   = bus.i_miss_addr[ADDR_WIDTH-1:4];
                        cnt_load = 1'b1;
`ifdef FILL_CRITICAL_WORD_FIRST_EN
                        cnt_start = bus.i_miss_addr[3:1];
`else
                        cnt_start = 3'd0;
`endif
                        state_d  = ST_FILL;
                    end
                end

                ST_FILL: begin
                    bus.fill_sel = sel_q;
                    if (!issue_done) begin
                        bus.mem_enable = 1'b1;
                        bus.mem_addr   = {base_q, issue_idx, 1'b0};
                        issue_en       = 1'b1;
                    end
                    // Returns arrive in issue order, so the receive index tracks the issue index.
                    if (bus.mem_data_valid) begin
                        bus.fill_we       = 1'b1;
                        bus.fill_data     = bus.mem_data_out;
                        bus.fill_word_idx = recv_idx;
                        recv_en           = 1'b1;
                        if (recv_last) begin
                            bus.d_fill_done = (sel_q == FILL_SEL_D);
                            bus.i_fill_done = (sel_q == FILL_SEL_I);
                            state_d         = ST_DONE;
                        end
                    end
                end

                ST_DONE: state_d = ST_IDLE;

                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            base_q  <= '0;
            sel_q   <= FILL_SEL_I;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            sel_q   <= sel_d;
        end
    end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Directed bench for cache_fill_ctrl with a 4-cycle read-latency memory model.
// Works in both builds; expectations follow FILL_CRITICAL_WORD_FIRST_EN.
module tb_cache_fill_ctrl;
    import cache_fill_ctrl_pkg::*;

`ifdef FILL_CRITICAL_WORD_FIRST_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    logic clk;
    logic rst;
    logic stray_valid;
    int   vec_count;
    int   miss_count;

    cache_fill_ctrl_if #(.ADDR_WIDTH(16)) bus ();

    cache_fill_ctrl #(.ADDR_WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] rdWord(input logic [15:0] a);
        return a ^ 16'hC3A5;
    endfunction

    // Memory model: a read sampled at a clock edge returns MEM_READ_LATENCY cycles later.
    logic [MEM_READ_LATENCY-1:0] pv;
    logic [15:0]                 pa [MEM_READ_LATENCY];

    always @(posedge clk) begin
        if (rst) begin
            pv <= '0;
        end else begin
            pv    <= {pv[MEM_READ_LATENCY-2:0], bus.mem_enable & ~bus.mem_wr};
            pa[0] <= bus.mem_addr;
            for (int k = 1; k < MEM_READ_LATENCY; k++) pa[k] <= pa[k-1];
        end
    end

    assign bus.mem_data_valid = pv[MEM_READ_LATENCY-1] | stray_valid;
    assign bus.mem_data_out   = pv[MEM_READ_LATENCY-1] ? rdWord(pa[MEM_READ_LATENCY-1]) :
                                (stray_valid ? 16'hDEAD : 16'h0000);

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_count++;
        assert (obs === exp) else begin
            miss_count++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic i_m, input logic [15:0] i_a,
                                 input logic d_m, input logic [15:0] d_a,
                                 input logic wr, input logic [15:0] wr_a, input logic [15:0] wr_d);
        bus.i_miss      = i_m;
        bus.i_miss_addr = i_a;
        bus.d_miss      = d_m;
        bus.d_miss_addr = d_a;
        bus.d_wr_req    = wr;
        bus.d_wr_addr   = wr_a;
        bus.d_wr_data   = wr_d;
    endtask

    task automatic nextCycle();
        @(negedge clk);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_mem_en"},  bus.mem_enable, 0);
        checkOutput({tag, "_mem_wr"},  bus.mem_wr, 0);
        checkOutput({tag, "_mem_addr"}, bus.mem_addr, 0);
        checkOutput({tag, "_mem_din"}, bus.mem_data_in, 0);
        checkOutput({tag, "_ack"},     bus.d_wr_ack, 0);
        checkOutput({tag, "_fill_we"}, bus.fill_we, 0);
        checkOutput({tag, "_fill_dat"}, bus.fill_data, 0);
        checkOutput({tag, "_fill_idx"}, bus.fill_word_idx, 0);
        checkOutput({tag, "_fill_sel"}, bus.fill_sel, 0);
        checkOutput({tag, "_i_done"},  bus.i_fill_done, 0);
        checkOutput({tag, "_d_done"},  bus.d_fill_done, 0);
    endtask

    // Caller has set the miss for cycle 0 at the current negedge; runs cycles 0..13.
    task automatic fillSequence(input logic sel, input logic [15:0] base, input logic [2:0] start,
                                input bit hold_store, input int drop_cycle);
        int idx;
        #1;
        checkOutput("acc_mem_en", bus.mem_enable, 0);
        checkOutput("acc_fill_we", bus.fill_we, 0);
        for (int c = 1; c <= 13; c++) begin
            nextCycle();
            if (hold_store && c == 1) begin
                bus.d_wr_req  = 1'b1;
                bus.d_wr_addr = 16'h0060;
                bus.d_wr_data = 16'h1234;
            end
            if (c == drop_cycle) begin
                if (sel) bus.d_miss = 1'b0;
                else     bus.i_miss = 1'b0;
            end
            #1;
            checkOutput("fill_mem_en", bus.mem_enable, (c >= 1 && c <= 8));
            checkOutput("fill_mem_wr", bus.mem_wr, 0);
            checkOutput("fill_wr_ack", bus.d_wr_ack, 0);
            if (c >= 1 && c <= 8)
                checkOutput("fill_mem_addr", bus.mem_addr, base + 16'(((start + c - 1) % 8) * 2));
            checkOutput("fill_we", bus.fill_we, (c >= 5 && c <= 12));
            if (c >= 5 && c <= 12) begin
                idx = (start + c - 5) % 8;
                checkOutput("fill_idx", bus.fill_word_idx, idx);
                checkOutput("fill_sel", bus.fill_sel, sel);
                checkOutput("fill_data", bus.fill_data, rdWord(base + 16'(idx * 2)));
            end
            checkOutput("i_fill_done", bus.i_fill_done, (c == 12 && !sel));
            checkOutput("d_fill_done", bus.d_fill_done, (c == 12 && sel));
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_count   = 0;
        miss_count  = 0;
        stray_valid = 1'b0;
        rst         = 1'b1;
        applyStimulus(0, 16'h0, 0, 16'h0, 0, 16'h0, 16'h0);
        repeat (3) nextCycle();
        rst = 1'b0;
        #1;
        checkAllZero("reset");

        // I-miss in block 0x0120; missed word 2
        nextCycle();
        applyStimulus(1, 16'h0124, 0, 16'h0, 0, 16'h0, 16'h0);
        fillSequence(FILL_SEL_I, 16'h0120, CWF ? 3'd2 : 3'd0, 0, 13);

        // Word 5 missed; miss dropped early, fill must still complete
        nextCycle();
        applyStimulus(1, 16'h012A, 0, 16'h0, 0, 16'h0, 16'h0);
        fillSequence(FILL_SEL_I, 16'h0120, CWF ? 3'd5 : 3'd0, 0, 3);

        // Simultaneous misses: D first, I accepted at cycle 14
        nextCycle();
        applyStimulus(1, 16'h0340, 1, 16'h0200, 0, 16'h0, 16'h0);
        fillSequence(FILL_SEL_D, 16'h0200, 3'd0, 0, 13);
        nextCycle();
        fillSequence(FILL_SEL_I, 16'h0340, 3'd0, 0, 13);

        // Store beats a D-miss in the same cycle
        nextCycle();
        applyStimulus(0, 16'h0, 1, 16'h0400, 1, 16'h0040, 16'hBEEF);
        #1;
        checkOutput("st_ack", bus.d_wr_ack, 1);
        checkOutput("st_mem_en", bus.mem_enable, 1);
        checkOutput("st_mem_wr", bus.mem_wr, 1);
        checkOutput("st_mem_addr", bus.mem_addr, 16'h0040);
        checkOutput("st_mem_din", bus.mem_data_in, 16'hBEEF);
        checkOutput("st_fill_we", bus.fill_we, 0);
        nextCycle();
        bus.d_wr_req = 1'b0;
        fillSequence(FILL_SEL_D, 16'h0400, 3'd0, 1, 13);

        // Store held through the fill is acked once back in IDLE, then back-to-back
        nextCycle();
        #1;
        checkOutput("held_ack", bus.d_wr_ack, 1);
        checkOutput("held_mem_wr", bus.mem_wr, 1);
        checkOutput("held_mem_addr", bus.mem_addr, 16'h0060);
        checkOutput("held_mem_din", bus.mem_data_in, 16'h1234);
        nextCycle();
        applyStimulus(0, 16'h0, 0, 16'h0, 1, 16'h0062, 16'h5678);
        #1;
        checkOutput("b2b_ack", bus.d_wr_ack, 1);
        checkOutput("b2b_mem_addr", bus.mem_addr, 16'h0062);
        checkOutput("b2b_mem_din", bus.mem_data_in, 16'h5678);
        nextCycle();
        applyStimulus(0, 16'h0, 0, 16'h0, 0, 16'h0, 16'h0);

        // Read data while idle must not produce a fill write
        stray_valid = 1'b1;
        #1;
        checkOutput("stray_fill_we", bus.fill_we, 0);
        checkOutput("stray_fill_dat", bus.fill_data, 0);
        checkOutput("stray_i_done", bus.i_fill_done, 0);
        nextCycle();
        stray_valid = 1'b0;

        // Reset at cycle 7 of a fill
        nextCycle();
        applyStimulus(1, 16'h0500, 0, 16'h0, 0, 16'h0, 16'h0);
        for (int c = 1; c <= 6; c++) nextCycle();
        nextCycle();
        rst = 1'b1;
        applyStimulus(0, 16'h0, 0, 16'h0, 0, 16'h0, 16'h0);
        nextCycle();
        rst = 1'b0;
        #1;
        checkAllZero("post_rst");
        for (int k = 0; k < 6; k++) begin
            nextCycle();
            #1;
            checkOutput("post_rst_fill_we", bus.fill_we, 0);
            checkOutput("post_rst_mem_en", bus.mem_enable, 0);
        end
        nextCycle();
        applyStimulus(1, 16'h0500, 0, 16'h0, 0, 16'h0, 16'h0);
        fillSequence(FILL_SEL_I, 16'h0500, 3'd0, 0, 13);

        nextCycle();
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
